// File: rtl/traffic_light_ctrl_param.sv
// Two-street traffic light controller with pedestrian phase, max-green limit on
// street B and a night flash mode. All lamps are Moore-decoded from the state.
module traffic_light_ctrl_param #(
    parameter int GREEN_MIN   = 6,
    parameter int GREEN_MAX_B = 16,
    parameter int YELLOW_T    = 2,
    parameter int ALL_RED_T   = 1,
    parameter int WALK_T      = 4,
    parameter int FLASH_T     = 8,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic Sa,
    input  logic Sb,
    input  logic ped_req,
    input  logic flash,
    output logic Ra,
    output logic Ya,
    output logic Ga,
    output logic Rb,
    output logic Yb,
    output logic Gb,
    output logic walk,
    output logic ped_pending
);

    // Four-bit encoding leaves spare codes so a corrupted register can be steered to AR_BA.
    typedef enum logic [3:0] {
        A_GRN = 4'd0,
        A_YEL = 4'd1,
        PED   = 4'd2,
        AR_AB = 4'd3,
        B_GRN = 4'd4,
        B_YEL = 4'd5,
        AR_BA = 4'd6,
        FLSH  = 4'd7
    } state_e;

    localparam logic [CNT_W-1:0] GMIN_LAST  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAXB_LAST = CNT_W'(GREEN_MAX_B - 1);
    localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_T - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic              pedPending_q, pedPending_d;
    logic              blink_q, blink_d;
    logic [CNT_W-1:0]  blinkCnt_q, blinkCnt_d;
    logic              stateChange;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= AR_BA;
            timer_q      <= '0;
            pedPending_q <= 1'b0;
            blink_q      <= 1'b1;
            blinkCnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pedPending_q <= pedPending_d;
            blink_q      <= blink_d;
            blinkCnt_q   <= blinkCnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pedPending_d = pedPending_q | ped_req;
        unique case (state_q)
            A_GRN: begin
                if (timer_q >= GMIN_LAST && (Sb || pedPending_q || flash))
                    state_d = A_YEL;
            end
            A_YEL: begin
                if (timer_q == YEL_LAST)
                    state_d = pedPending_q ? PED : AR_AB;
            end
            PED: begin
                // A request arriving on the exit cycle must survive the clear.
                if (timer_q == WALK_LAST) begin
                    state_d      = AR_AB;
                    pedPending_d = ped_req;
                end
            end
            AR_AB: begin
                if (timer_q == AR_LAST) begin
                    if (flash)
                        state_d = FLSH;
                    else if (Sb)
                        state_d = B_GRN;
                    else
                        state_d = AR_BA;
                end
            end
            B_GRN: begin
                if ((timer_q >= GMIN_LAST && (Sa || !Sb || flash)) || timer_q >= GMAXB_LAST)
                    state_d = B_YEL;
            end
            B_YEL: begin
                if (timer_q == YEL_LAST)
                    state_d = AR_BA;
            end
            AR_BA: begin
                if (timer_q == AR_LAST)
                    state_d = flash ? FLSH : A_GRN;
            end
            FLSH: begin
                if (!flash)
                    state_d = AR_BA;
            end
            default: state_d = AR_BA;
        endcase
    end

    // Saturating so an indefinitely held A green never wraps back below the minimum.
    assign stateChange = (state_d != state_q);
    always_comb begin
        timer_d = timer_q;
        if (stateChange)
            timer_d = '0;
        else if (timer_q != '1)
            timer_d = timer_q + CNT_W'(1);
    end

    always_comb begin
        blink_d    = blink_q;
        blinkCnt_d = blinkCnt_q;
        if (state_d == FLSH && state_q != FLSH) begin
            blink_d    = 1'b1;
            blinkCnt_d = '0;
        end else if (state_q == FLSH) begin
            if (blinkCnt_q == FLASH_LAST) begin
                blink_d    = ~blink_q;
                blinkCnt_d = '0;
            end else begin
                blinkCnt_d = blinkCnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        Ra   = 1'b0;
        Ya   = 1'b0;
        Ga   = 1'b0;
        Rb   = 1'b0;
        Yb   = 1'b0;
        Gb   = 1'b0;
        walk = 1'b0;
        unique case (state_q)
            A_GRN: begin Ga = 1'b1; Rb = 1'b1; end
            A_YEL: begin Ya = 1'b1; Rb = 1'b1; end
            PED:   begin Ra = 1'b1; Rb = 1'b1; walk = 1'b1; end
            AR_AB: begin Ra = 1'b1; Rb = 1'b1; end
            B_GRN: begin Ra = 1'b1; Gb = 1'b1; end
            B_YEL: begin Ra = 1'b1; Yb = 1'b1; end
            AR_BA: begin Ra = 1'b1; Rb = 1'b1; end
            FLSH:  begin Ya = blink_q; Rb = blink_q; end
            default: begin Ra = 1'b1; Rb = 1'b1; end
        endcase
    end

    assign ped_pending = pedPending_q;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Bench for traffic_light_ctrl_param: directed scenarios then randomized traffic,
// every cycle compared against a phase/elapsed-time reference model.
module tb_traffic_light_ctrl_param;

    localparam int GREEN_MIN   = 4;
    localparam int GREEN_MAX_B = 8;
    localparam int YELLOW_T    = 2;
    localparam int ALL_RED_T   = 1;
    localparam int WALK_T      = 3;
    localparam int FLASH_T     = 2;
    localparam int CNT_W       = 8;

    localparam int P_AGRN = 0, P_AYEL = 1, P_PED = 2, P_ARAB = 3;
    localparam int P_BGRN = 4, P_BYEL = 5, P_ARBA = 6, P_FLSH = 7;
    localparam int L_GA = 0, L_YA = 1, L_GB = 2, L_YB = 3, L_WALK = 4;

    logic clk = 1'b0;
    logic reset_n, Sa, Sb, ped_req, flash;
    logic Ra, Ya, Ga, Rb, Yb, Gb, walk, ped_pending;

    int checks = 0;
    int errors = 0;

    int mPhase;
    int mElapsed;
    bit mPend;

    always #5 clk = ~clk;

    traffic_light_ctrl_param #(
        .GREEN_MIN(GREEN_MIN), .GREEN_MAX_B(GREEN_MAX_B), .YELLOW_T(YELLOW_T),
        .ALL_RED_T(ALL_RED_T), .WALK_T(WALK_T), .FLASH_T(FLASH_T), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .Sa(Sa), .Sb(Sb), .ped_req(ped_req), .flash(flash),
        .Ra(Ra), .Ya(Ya), .Ga(Ga), .Rb(Rb), .Yb(Yb), .Gb(Gb), .walk(walk),
        .ped_pending(ped_pending)
    );

    task automatic modelReset();
        mPhase   = P_ARBA;
        mElapsed = 1;
        mPend    = 1'b0;
    endtask

    // mElapsed counts the cycles spent in the current phase, 1 on its first cycle.
    task automatic modelStep();
        int nxt;
        bit pendN;
        nxt   = mPhase;
        pendN = mPend | ped_req;
        case (mPhase)
            P_AGRN: if (mElapsed >= GREEN_MIN && (Sb || mPend || flash)) nxt = P_AYEL;
            P_AYEL: if (mElapsed == YELLOW_T) nxt = mPend ? P_PED : P_ARAB;
            P_PED:  if (mElapsed == WALK_T) begin nxt = P_ARAB; pendN = ped_req; end
            P_ARAB: if (mElapsed == ALL_RED_T) nxt = flash ? P_FLSH : (Sb ? P_BGRN : P_ARBA);
            P_BGRN: if ((mElapsed >= GREEN_MIN && (Sa || !Sb || flash)) || mElapsed >= GREEN_MAX_B)
                        nxt = P_BYEL;
            P_BYEL: if (mElapsed == YELLOW_T) nxt = P_ARBA;
            P_ARBA: if (mElapsed == ALL_RED_T) nxt = flash ? P_FLSH : P_AGRN;
            default: if (!flash) nxt = P_ARBA;
        endcase
        mElapsed = (nxt == mPhase) ? mElapsed + 1 : 1;
        mPhase   = nxt;
        mPend    = pendN;
    endtask

    // Vector order: {Ra, Ya, Ga, Rb, Yb, Gb, walk, ped_pending}
    function automatic logic [7:0] expectedLamps();
        logic ra, ya, ga, rb, yb, gb, wk, blink;
        {ra, ya, ga, rb, yb, gb, wk} = '0;
        blink = (((mElapsed - 1) / FLASH_T) % 2) == 0;
        case (mPhase)
            P_AGRN: begin ga = 1; rb = 1; end
            P_AYEL: begin ya = 1; rb = 1; end
            P_PED:  begin ra = 1; rb = 1; wk = 1; end
            P_BGRN: begin ra = 1; gb = 1; end
            P_BYEL: begin ra = 1; yb = 1; end
            P_FLSH: begin ya = blink; rb = blink; end
            default: begin ra = 1; rb = 1; end
        endcase
        return {ra, ya, ga, rb, yb, gb, wk, mPend};
    endfunction

    function automatic logic lampOf(int which);
        case (which)
            L_GA:    return Ga;
            L_YA:    return Ya;
            L_GB:    return Gb;
            L_YB:    return Yb;
            default: return walk;
        endcase
    endfunction

    task automatic checkOutput(input string tag);
        logic [7:0] obs, exp;
        obs = {Ra, Ya, Ga, Rb, Yb, Gb, walk, ped_pending};
        exp = expectedLamps();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive inputs after a falling edge, advance one rising edge, compare at the next fall.
    task automatic applyStimulus(input logic sa, input logic sb, input logic pr,
                                 input logic fl, input string tag);
        Sa = sa; Sb = sb; ped_req = pr; flash = fl;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic runWhile(input logic sa, input logic sb, input logic pr, input logic fl,
                            input int which, input string tag, output int n);
        n = 0;
        while (lampOf(which) === 1'b1 && n < 100) begin
            n++;
            applyStimulus(sa, sb, pr, fl, tag);
        end
    endtask

    task automatic asyncReset(input string tag);
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput(tag);
        @(negedge clk);
        checkOutput(tag);
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [7:0] yaPat, rbPat;
        logic fr;

        reset_n = 1'b0; Sa = 0; Sb = 0; ped_req = 0; flash = 0;
        modelReset();
        @(negedge clk);
        checkOutput("reset_hold");
        reset_n = 1'b1;
        checkOutput("post_release");

        for (int i = 0; i < 50; i++) applyStimulus(0, 0, 0, 0, "idle_a");
        checkValue("idle_ga_held", Ga, 1);

        asyncReset("reset_bdem");
        applyStimulus(0, 0, 0, 0, "bdem_enter");
        runWhile(0, 1, 0, 0, L_GA, "bdem_ga", n);
        checkValue("bdem_ga_len", n, GREEN_MIN);
        runWhile(0, 1, 0, 0, L_YA, "bdem_ya", n);
        checkValue("bdem_ya_len", n, YELLOW_T);
        applyStimulus(0, 1, 0, 0, "bdem_arab");
        checkValue("bdem_gb_on", Gb, 1);
        applyStimulus(0, 1, 0, 0, "bdem_gb0");
        runWhile(0, 0, 0, 0, L_GB, "bdem_gb", n);
        checkValue("bdem_gb_len", n + 1, GREEN_MIN);
        runWhile(0, 0, 0, 0, L_YB, "bdem_yb", n);
        checkValue("bdem_yb_len", n, YELLOW_T);
        applyStimulus(0, 0, 0, 0, "bdem_back");
        checkValue("bdem_ga_back", Ga, 1);

        runWhile(0, 1, 0, 0, L_GA, "max_ga", n);
        runWhile(0, 1, 0, 0, L_YA, "max_ya", n);
        applyStimulus(0, 1, 0, 0, "max_arab");
        runWhile(0, 1, 0, 0, L_GB, "max_gb", n);
        checkValue("maxgreen_gb_len", n, GREEN_MAX_B);
        checkValue("maxgreen_yb", Yb, 1);

        asyncReset("reset_ped");
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, "ped_idle");
        applyStimulus(0, 0, 1, 0, "ped_pulse");
        checkValue("ped_pending_set", ped_pending, 1);
        applyStimulus(0, 0, 0, 0, "ped_to_yel");
        runWhile(0, 0, 0, 0, L_YA, "ped_ya", n);
        checkValue("ped_ya_len", n, YELLOW_T);
        runWhile(0, 0, 0, 0, L_WALK, "ped_walk", n);
        checkValue("ped_walk_len", n, WALK_T);
        checkValue("ped_cleared", ped_pending, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, "ped_allred");
        checkValue("ped_back_ga", Ga, 1);

        runWhile(0, 1, 0, 0, L_GA, "fl_ga", n);
        runWhile(0, 1, 0, 0, L_YA, "fl_ya", n);
        applyStimulus(0, 1, 0, 0, "fl_arab");
        applyStimulus(0, 1, 0, 1, "fl_raise");
        runWhile(0, 1, 0, 1, L_GB, "fl_gb", n);
        runWhile(0, 1, 0, 1, L_YB, "fl_yb", n);
        checkValue("fl_yb_len", n, YELLOW_T);
        applyStimulus(0, 1, 0, 1, "fl_enter");
        for (int i = 0; i < 8; i++) begin
            yaPat[7-i] = Ya;
            rbPat[7-i] = Rb;
            applyStimulus(0, 0, 0, 1, "fl_blink");
        end
        checkValue("flash_ya_pattern", int'(yaPat), int'(8'b11001100));
        checkValue("flash_rb_pattern", int'(rbPat), int'(8'b11001100));
        applyStimulus(0, 0, 0, 0, "fl_drop");
        checkValue("fl_drop_allred", int'({Ra, Rb, Ya}), int'(3'b110));
        applyStimulus(0, 0, 0, 0, "fl_ga");
        checkValue("fl_back_ga", Ga, 1);

        runWhile(0, 1, 0, 0, L_GA, "ar_ga", n);
        runWhile(0, 1, 0, 0, L_YA, "ar_ya", n);
        applyStimulus(0, 1, 0, 0, "ar_arab");
        applyStimulus(0, 1, 1, 0, "ar_pend_bgrn");
        checkValue("ar_pending_in_bgrn", ped_pending, 1);
        asyncReset("async_rst_bgrn");
        checkValue("async_gb_off", Gb, 0);

        fr = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                asyncReset("rand_reset");
            end else begin
                if ($urandom_range(0, 19) == 0) fr = ~fr;
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 9) == 0), fr, "random");
                checks++;
                assert (!((Ga | Ya) & (Gb | Yb))) else begin
                    errors++;
                    $error("[TB] FAIL safety: observed A=%b%b B=%b%b expected no overlap",
                           Ga, Ya, Gb, Yb);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
